// File: rtl/tx_clk_mgr_if.sv
// Signal bundle between the TX clock supervisor and its surroundings:
// DCM lock/reset, TX engine reset, status and management counters.
interface tx_clk_mgr_if #(
  parameter int CNT_W = 8
);
  logic             dcm_locked;
  logic             cnt_clr;
  logic             dcm_rst;
  logic             tx_rst;
  logic             clk_ok;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] retry_cnt;
  logic [CNT_W-1:0] loss_cnt;

  // Surrounding logic: supplies the lock indication and counter clear.
  modport master (
    output dcm_locked,
    output cnt_clr,
    input  dcm_rst,
    input  tx_rst,
    input  clk_ok,
    input  state_o,
    input  retry_cnt,
    input  loss_cnt
  );

  // Supervisor side.
  modport slave (
    input  dcm_locked,
    input  cnt_clr,
    output dcm_rst,
    output tx_rst,
    output clk_ok,
    output state_o,
    output retry_cnt,
    output loss_cnt
  );
endinterface

// File: rtl/tx_clk_mgr.sv
// Transmit clock supervisor. Pulses the TX DCM reset, waits for a stable
// synchronized lock, then releases the TX engine reset. Lock timeouts and
// lock losses restart the sequence and are tallied in saturating counters.
//
// state     | meaning
// ----------+--------------------------------------------------------
// DCM_RST   | dcm_rst held high for RST_CYCLES cycles
// WAIT_LOCK | DCM released, waiting up to LOCK_TIMEOUT cycles for lock
// STABLE    | lock seen, must hold for STABLE_CYCLES consecutive cycles
// RUN       | clock good, TX engine out of reset
module tx_clk_mgr #(
  parameter int RST_CYCLES    = 4,
  parameter int LOCK_TIMEOUT  = 1024,
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 8
) (
  input  logic         txclk_in,
  input  logic         reset,
  tx_clk_mgr_if.slave  bus
);

  typedef enum logic [1:0] {
    DCM_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam int MAX_A   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CYC = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
  localparam int TMR_W   = $clog2(MAX_CYC + 1);

  // The timer counts down to a terminal value of 1. DCM_RST is always
  // entered with the timer at 0 (including out of async reset), so the
  // first DCM_RST cycle loads RST_CYCLES-1 and the state lasts RST_CYCLES.
  localparam logic [TMR_W-1:0] TMR_ONE     = TMR_W'(1);
  localparam logic [TMR_W-1:0] RST_LOAD    = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] LOCK_LOAD   = TMR_W'(LOCK_TIMEOUT);
  localparam logic [TMR_W-1:0] STABLE_LOAD = TMR_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [TMR_W-1:0] r_timer;
  logic [TMR_W-1:0] w_timer_nxt;
  logic             w_retry_evt;
  logic             w_loss_evt;

  logic             r_sync1;
  logic             r_lock_s;

  logic             r_dcm_rst;
  logic             r_tx_rst;
  logic             r_clk_ok;
  logic [CNT_W-1:0] r_retry_cnt;
  logic [CNT_W-1:0] r_loss_cnt;

  // Two-flop lock synchronizer; flushed while the DCM is held in reset so a
  // stale lock from before the reset pulse cannot be trusted afterwards.
  always_ff @(posedge txclk_in or negedge reset) begin
    if (!reset) begin
      r_sync1  <= 1'b0;
      r_lock_s <= 1'b0;
    end else if (r_dcm_rst) begin
      r_sync1  <= 1'b0;
      r_lock_s <= 1'b0;
    end else begin
      r_sync1  <= bus.dcm_locked;
      r_lock_s <= r_sync1;
    end
  end

  // Next-state, timer and counter-event decode.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_retry_evt = 1'b0;
    w_loss_evt  = 1'b0;
    case (r_state)
      DCM_RST: begin
        if (r_timer == '0) begin
          w_timer_nxt = RST_LOAD;
        end else if (r_timer == TMR_ONE) begin
          w_state_nxt = WAIT_LOCK;
          w_timer_nxt = LOCK_LOAD;
        end else begin
          w_timer_nxt = r_timer - TMR_ONE;
        end
      end
      WAIT_LOCK: begin
        // Lock is tested before the terminal count so it wins a tie.
        if (r_lock_s) begin
          w_state_nxt = STABLE;
          w_timer_nxt = STABLE_LOAD;
        end else if (r_timer == TMR_ONE) begin
          w_state_nxt = DCM_RST;
          w_timer_nxt = '0;
          w_retry_evt = 1'b1;
        end else begin
          w_timer_nxt = r_timer - TMR_ONE;
        end
      end
      STABLE: begin
        // A dropout here is a glitch: re-wait for lock, no DCM reset.
        if (!r_lock_s) begin
          w_state_nxt = WAIT_LOCK;
          w_timer_nxt = LOCK_LOAD;
        end else if (r_timer == TMR_ONE) begin
          w_state_nxt = RUN;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer - TMR_ONE;
        end
      end
      RUN: begin
        if (!r_lock_s) begin
          w_state_nxt = DCM_RST;
          w_timer_nxt = '0;
          w_loss_evt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = DCM_RST;
        w_timer_nxt = '0;
      end
    endcase
  end

  // State and timer registers.
  always_ff @(posedge txclk_in or negedge reset) begin
    if (!reset) begin
      r_state <= DCM_RST;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  // Outputs registered from the next state so they move with the FSM.
  always_ff @(posedge txclk_in or negedge reset) begin
    if (!reset) begin
      r_dcm_rst <= 1'b1;
      r_tx_rst  <= 1'b1;
      r_clk_ok  <= 1'b0;
    end else begin
      r_dcm_rst <= (w_state_nxt == DCM_RST);
      r_tx_rst  <= (w_state_nxt != RUN);
      r_clk_ok  <= (w_state_nxt == RUN);
    end
  end

  // Saturating event counters; a clear beats a same-cycle increment.
  always_ff @(posedge txclk_in or negedge reset) begin
    if (!reset) begin
      r_retry_cnt <= '0;
      r_loss_cnt  <= '0;
    end else if (bus.cnt_clr) begin
      r_retry_cnt <= '0;
      r_loss_cnt  <= '0;
    end else begin
      if (w_retry_evt && (r_retry_cnt != CNT_MAX)) begin
        r_retry_cnt <= r_retry_cnt + 1'b1;
      end
      if (w_loss_evt && (r_loss_cnt != CNT_MAX)) begin
        r_loss_cnt <= r_loss_cnt + 1'b1;
      end
    end
  end

  assign bus.dcm_rst   = r_dcm_rst;
  assign bus.tx_rst    = r_tx_rst;
  assign bus.clk_ok    = r_clk_ok;
  assign bus.state_o   = r_state;
  assign bus.retry_cnt = r_retry_cnt;
  assign bus.loss_cnt  = r_loss_cnt;

endmodule

// File: tb/tb_tx_clk_mgr.sv
// Directed bench for tx_clk_mgr: default-parameter instance for the lock
// sequence, retries, glitch, loss and async reset; a CNT_W=2 instance with a
// short timeout for counter saturation and clear-versus-increment.
module tb_tx_clk_mgr;

  logic clk;
  logic rst_a_n;
  logic rst_b_n;

  int n_total;
  int n_pass;

  tx_clk_mgr_if #(.CNT_W(8)) if_a ();
  tx_clk_mgr_if #(.CNT_W(2)) if_b ();

  tx_clk_mgr #(
    .RST_CYCLES(4), .LOCK_TIMEOUT(1024), .STABLE_CYCLES(16), .CNT_W(8)
  ) u_dut_a (
    .txclk_in (clk),
    .reset    (rst_a_n),
    .bus      (if_a.slave)
  );

  tx_clk_mgr #(
    .RST_CYCLES(4), .LOCK_TIMEOUT(32), .STABLE_CYCLES(16), .CNT_W(2)
  ) u_dut_b (
    .txclk_in (clk),
    .reset    (rst_b_n),
    .bus      (if_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    if_a.dcm_locked = 1'b1;
    if_a.cnt_clr    = 1'b0;
    if_b.dcm_locked = 1'b0;
    if_b.cnt_clr    = 1'b0;

    // Reset values
    cyc(1);
    chk("rst_state",   32'(if_a.state_o),   32'd0);
    chk("rst_dcm_rst", 32'(if_a.dcm_rst),   32'd1);
    chk("rst_tx_rst",  32'(if_a.tx_rst),    32'd1);
    chk("rst_clk_ok",  32'(if_a.clk_ok),    32'd0);
    chk("rst_retry",   32'(if_a.retry_cnt), 32'd0);
    chk("rst_loss",    32'(if_a.loss_cnt),  32'd0);

    // Lock held high from release: DCM_RST edges 1-3, WAIT_LOCK at edge 4,
    // STABLE at 7, RUN at 23 (19 cycles after entering WAIT_LOCK).
    rst_a_n = 1'b1;
    cyc(3);
    chk("up_e3_dcm_rst", 32'(if_a.dcm_rst), 32'd1);
    chk("up_e3_state",   32'(if_a.state_o), 32'd0);
    cyc(1);
    chk("up_e4_dcm_rst", 32'(if_a.dcm_rst), 32'd0);
    chk("up_e4_state",   32'(if_a.state_o), 32'd1);
    cyc(2);
    chk("up_e6_state",   32'(if_a.state_o), 32'd1);
    cyc(1);
    chk("up_e7_state",   32'(if_a.state_o), 32'd2);
    cyc(15);
    chk("up_e22_state",  32'(if_a.state_o), 32'd2);
    chk("up_e22_tx_rst", 32'(if_a.tx_rst),  32'd1);
    cyc(1);
    chk("up_e23_state",  32'(if_a.state_o), 32'd3);
    chk("up_e23_tx_rst", 32'(if_a.tx_rst),  32'd0);
    chk("up_e23_clk_ok", 32'(if_a.clk_ok),  32'd1);

    // Lock loss in RUN: tx_rst rises 3 edges after the drop.
    if_a.dcm_locked = 1'b0;
    cyc(2);
    chk("loss_e25_tx_rst", 32'(if_a.tx_rst), 32'd0);
    chk("loss_e25_clk_ok", 32'(if_a.clk_ok), 32'd1);
    cyc(1);
    chk("loss_e26_tx_rst",  32'(if_a.tx_rst),   32'd1);
    chk("loss_e26_clk_ok",  32'(if_a.clk_ok),   32'd0);
    chk("loss_e26_dcm_rst", 32'(if_a.dcm_rst),  32'd1);
    chk("loss_e26_state",   32'(if_a.state_o),  32'd0);
    chk("loss_e26_cnt",     32'(if_a.loss_cnt), 32'd1);
    cyc(3);
    chk("loss_e29_dcm_rst", 32'(if_a.dcm_rst), 32'd1);
    cyc(1);
    chk("loss_e30_dcm_rst", 32'(if_a.dcm_rst), 32'd0);
    chk("loss_e30_state",   32'(if_a.state_o), 32'd1);

    // Lock stays low: timeouts at edges 1054, 2082, 3110.
    cyc(1023);
    chk("to1_pre_state", 32'(if_a.state_o),   32'd1);
    chk("to1_pre_retry", 32'(if_a.retry_cnt), 32'd0);
    cyc(1);
    chk("to1_state",   32'(if_a.state_o),   32'd0);
    chk("to1_dcm_rst", 32'(if_a.dcm_rst),   32'd1);
    chk("to1_retry",   32'(if_a.retry_cnt), 32'd1);
    chk("to1_tx_rst",  32'(if_a.tx_rst),    32'd1);
    cyc(4);
    chk("to1_rel_state", 32'(if_a.state_o), 32'd1);
    cyc(1024);
    chk("to2_state", 32'(if_a.state_o),   32'd0);
    chk("to2_retry", 32'(if_a.retry_cnt), 32'd2);
    cyc(1028);
    chk("to3_retry",  32'(if_a.retry_cnt), 32'd3);
    chk("to3_tx_rst", 32'(if_a.tx_rst),    32'd1);
    chk("to3_loss",   32'(if_a.loss_cnt),  32'd1);

    // Relock, then a one-cycle dropout in STABLE.
    cyc(1);
    if_a.dcm_locked = 1'b1;
    cyc(2);
    chk("gl_e3113_state", 32'(if_a.state_o), 32'd0);
    cyc(1);
    chk("gl_e3114_state", 32'(if_a.state_o), 32'd1);
    cyc(3);
    chk("gl_e3117_state", 32'(if_a.state_o), 32'd2);
    cyc(5);
    if_a.dcm_locked = 1'b0;
    cyc(1);
    if_a.dcm_locked = 1'b1;
    chk("gl_e3123_state", 32'(if_a.state_o), 32'd2);
    cyc(2);
    chk("gl_e3125_state",   32'(if_a.state_o),  32'd1);
    chk("gl_e3125_dcm_rst", 32'(if_a.dcm_rst),  32'd0);
    chk("gl_e3125_loss",    32'(if_a.loss_cnt), 32'd1);
    cyc(1);
    chk("gl_e3126_state", 32'(if_a.state_o), 32'd2);
    cyc(15);
    chk("gl_e3141_state",  32'(if_a.state_o), 32'd2);
    chk("gl_e3141_tx_rst", 32'(if_a.tx_rst),  32'd1);
    cyc(1);
    chk("gl_e3142_state",  32'(if_a.state_o), 32'd3);
    chk("gl_e3142_tx_rst", 32'(if_a.tx_rst),  32'd0);

    // Async reset in RUN, observed before any clock edge.
    #1 rst_a_n = 1'b0;
    #1;
    chk("ar_state",   32'(if_a.state_o),   32'd0);
    chk("ar_dcm_rst", 32'(if_a.dcm_rst),   32'd1);
    chk("ar_tx_rst",  32'(if_a.tx_rst),    32'd1);
    chk("ar_clk_ok",  32'(if_a.clk_ok),    32'd0);
    chk("ar_retry",   32'(if_a.retry_cnt), 32'd0);
    chk("ar_loss",    32'(if_a.loss_cnt),  32'd0);

    // CNT_W=2 instance, 32-cycle timeout: one timeout every 36 edges.
    cyc(1);
    rst_b_n = 1'b1;
    cyc(36);
    chk("b_to1_state", 32'(if_b.state_o),   32'd0);
    chk("b_to1_retry", 32'(if_b.retry_cnt), 32'd1);
    cyc(36);
    chk("b_to2_retry", 32'(if_b.retry_cnt), 32'd2);
    cyc(36);
    chk("b_to3_retry", 32'(if_b.retry_cnt), 32'd3);
    cyc(36);
    chk("b_to4_state", 32'(if_b.state_o),   32'd0);
    chk("b_to4_retry", 32'(if_b.retry_cnt), 32'd3);
    cyc(36);
    chk("b_to5_retry", 32'(if_b.retry_cnt), 32'd3);
    cyc(35);
    chk("b_pre6_state", 32'(if_b.state_o),   32'd1);
    chk("b_pre6_retry", 32'(if_b.retry_cnt), 32'd3);
    if_b.cnt_clr = 1'b1;
    cyc(1);
    if_b.cnt_clr = 1'b0;
    chk("b_to6_state",   32'(if_b.state_o),   32'd0);
    chk("b_to6_clr_win", 32'(if_b.retry_cnt), 32'd0);
    cyc(36);
    chk("b_to7_retry", 32'(if_b.retry_cnt), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
